// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two requesters share one combinational 16-bit ALU. Requests use a
// valid/ready handshake and are arbitrated round-robin. The operands of the
// winning request are registered onto the ALU inputs, the ALU result is
// captured one cycle later, and the response is held until it is acknowledged.
module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              req1_ready,
    output logic [OP_W-1:0]   alu_operation,
    output logic [DATA_W-1:0] alu_dataX,
    output logic [DATA_W-1:0] alu_dataY,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    input  logic              rsp_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   xfer;
    logic   xfer_id;

    // Grant decode and next-state: grants only in IDLE, ties go to the
    // requester that was not served last; a grant implies a transfer since
    // ready is only raised for a requester whose valid is high.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    if (req0_valid && req1_valid) begin
                        req0_ready = last_grant;
                        req1_ready = ~last_grant;
                    end else begin
                        req0_ready = req0_valid;
                        req1_ready = req1_valid;
                    end
                end
                if (req0_ready || req1_ready) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign xfer    = req0_ready | req1_ready;
    assign xfer_id = req1_ready;

    // State register plus operand launch, result capture and response hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            alu_operation <= '0;
            alu_dataX     <= '0;
            alu_dataY     <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_data      <= '0;
            rsp_zero      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (state == IDLE && xfer) begin
                alu_operation <= xfer_id ? req1_op : req0_op;
                alu_dataX     <= xfer_id ? req1_x  : req0_x;
                alu_dataY     <= xfer_id ? req1_y  : req0_y;
                rsp_id        <= xfer_id;
                last_grant    <= xfer_id;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_result;
                rsp_zero  <= (alu_result == '0);
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ack) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed and randomized bench for the two-requester ALU arbiter, with a
// behavioural ALU attached to the ALU-side ports and a reference model that
// tracks the round-robin owner and the expected response of each operation.
module tb_alu_share_arbiter;
    localparam int DATA_W = 16;
    localparam int OP_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic              req0_ready, req1_ready;
    logic [OP_W-1:0]   alu_operation;
    logic [DATA_W-1:0] alu_dataX, alu_dataY, alu_result;
    logic              rsp_valid, rsp_id, rsp_zero, rsp_ack, busy;
    logic [DATA_W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int exp_last = 1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
        .req1_ready(req1_ready),
        .alu_operation(alu_operation), .alu_dataX(alu_dataX), .alu_dataY(alu_dataY),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_ack(rsp_ack), .busy(busy)
    );

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
        case (op)
            3'd0:    return x + y;
            3'd1:    return x - y;
            default: return x & y;
        endcase
    endfunction

    assign alu_result = alu_f(alu_operation, alu_dataX, alu_dataY);

    // Who should win given the current valids and who was served last.
    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) return (exp_last == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration round from IDLE, through EXEC and RESP, back to IDLE.
    task automatic run_op(input bit v0, input logic [2:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                          input bit v1, input logic [2:0] o1, input logic [15:0] x1, input logic [15:0] y1,
                          input int ackd);
        int w;
        logic [2:0]  eop;
        logic [15:0] ex, ey, er;
        req0_valid = v0; req0_op = o0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_op = o1; req1_x = x1; req1_y = y1;
        #1;
        w = pick(v0, v1);
        chk("idle_ready0", 32'(req0_ready), 32'(w == 0));
        chk("idle_ready1", 32'(req1_ready), 32'(w == 1));
        if (w < 0) begin
            tick();
            chk("nogrant_busy", 32'(busy), 32'd0);
            chk("nogrant_rspv", 32'(rsp_valid), 32'd0);
            return;
        end
        eop = (w == 1) ? o1 : o0;
        ex  = (w == 1) ? x1 : x0;
        ey  = (w == 1) ? y1 : y0;
        er  = alu_f(eop, ex, ey);
        tick();
        exp_last = w;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rspv", 32'(rsp_valid), 32'd0);
        chk("exec_op", 32'(alu_operation), 32'(eop));
        chk("exec_x", 32'(alu_dataX), 32'(ex));
        chk("exec_y", 32'(alu_dataY), 32'(ey));
        chk("exec_ready0", 32'(req0_ready), 32'd0);
        chk("exec_ready1", 32'(req1_ready), 32'd0);
        if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        tick();
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_id", 32'(rsp_id), 32'(w));
        chk("resp_data", 32'(rsp_data), 32'(er));
        chk("resp_zero", 32'(rsp_zero), 32'(er == 16'h0000));
        for (int i = 0; i < ackd; i++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(er));
            chk("hold_id", 32'(rsp_id), 32'(w));
            chk("hold_x", 32'(alu_dataX), 32'(ex));
            chk("hold_op", 32'(alu_operation), 32'(eop));
            chk("hold_ready0", 32'(req0_ready), 32'd0);
            chk("hold_ready1", 32'(req1_ready), 32'd0);
        end
        rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        chk("ack_rspv", 32'(rsp_valid), 32'd0);
        chk("ack_busy", 32'(busy), 32'd0);
        chk("ack_x_kept", 32'(alu_dataX), 32'(ex));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rsp_ack = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd2; req0_x = 16'h1111; req0_y = 16'h2222;
        req1_valid = 1'b1; req1_op = 3'd1; req1_x = 16'h3333; req1_y = 16'h4444;
        // Reset with both requesters pending
        tick(); tick();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_op", 32'(alu_operation), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        exp_last = 1;

        // Single requester add
        run_op(1, 3'd0, 16'h0005, 16'h0003, 0, 3'd0, 16'h0, 16'h0, 0);

        // Fresh reset, then continuous ties alternate 0,1,0,1
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1; exp_last = 1;
        for (int k = 0; k < 4; k++)
            run_op(1, 3'd0, 16'h0100, 16'h0023, 1, 3'd1, 16'h1234, 16'h1234, 0);

        // Long held response with req1 pending, then req1 served
        run_op(1, 3'd2, 16'hF0F0, 16'h0FF0, 1, 3'd0, 16'h0001, 16'h0002, 10);
        run_op(0, 3'd0, 16'h0, 16'h0, 1, 3'd0, 16'h0001, 16'h0002, 0);

        // Wrap-around passed through with zero flag
        run_op(1, 3'd0, 16'hFFFF, 16'h0001, 0, 3'd0, 16'h0, 16'h0, 0);

        // Ack while idle is ignored
        rsp_ack = 1'b1;
        run_op(0, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0, 16'h0, 0);
        rsp_ack = 1'b0;

        // Reset during EXEC discards the operation and restores the tie owner
        run_op(1, 3'd0, 16'h0002, 16'h0002, 0, 3'd0, 16'h0, 16'h0, 0);
        req0_valid = 1'b1; req0_op = 3'd3; req0_x = 16'h00FF; req0_y = 16'h0F0F;
        #1;
        chk("mid_ready0", 32'(req0_ready), 32'd1);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; req0_valid = 1'b0;
        tick();
        chk("mid_rspv", 32'(rsp_valid), 32'd0);
        chk("mid_busy_rst", 32'(busy), 32'd0);
        chk("mid_op_rst", 32'(alu_operation), 32'd0);
        rst_n = 1'b1; exp_last = 1;
        tick();
        chk("mid_rspv_after", 32'(rsp_valid), 32'd0);
        chk("mid_busy_after", 32'(busy), 32'd0);
        run_op(1, 3'd1, 16'h0010, 16'h0001, 1, 3'd0, 16'h0020, 16'h0002, 0);

        // Randomized rounds against the reference model
        for (int r = 0; r < 40; r++) begin
            run_op(1'($urandom % 2), 3'($urandom % 8), 16'($urandom), 16'($urandom),
                   1'($urandom % 2), 3'($urandom % 8), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
